// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks a 3-input combinational block through all eight
// input combinations, captures its y output per row and compares the result
// against an expected table latched when the scan starts.
module truth_table_scanner #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] truth_table,
  output logic [7:0] mismatch
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned ROWS  = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROWS-1:0]   exp_q, exp_d;
  logic [ROWS-1:0]   tt_q, tt_d;
  logic [ROWS-1:0]   mism_q, mism_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ROWS-1:0]   tt_smp;

  // State and datapath registers; reset returns every output to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      mism_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      mism_q  <= mism_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state and next-output logic for the scan sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    mism_d  = mism_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    // Table as it will look once the current row's y is captured; the final
    // row feeds pass/mismatch in the same cycle it is stored.
    tt_smp        = tt_q;
    tt_smp[idx_q] = y;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          exp_d   = expected;
          tt_d    = '0;
          mism_d  = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        tt_d = tt_smp;
        if (idx_q == IDX_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (tt_smp == exp_q);
          mism_d  = tt_smp ^ exp_q;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign a           = idx_q[2];
  assign b           = idx_q[1];
  assign c           = idx_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign truth_table = tt_q;
  assign mismatch    = mism_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (settle 4 and settle 1), each
// wrapped around a lookup-table block; expectations are queued at start and
// checked by a cycle-accurate monitor against the scan timing rules.
module tb_truth_table_scanner;

  typedef struct {
    logic [7:0]  tbl;
    logic [7:0]  mism;
    logic        pass;
    int unsigned start_cyc;
  } sb_t;

  logic       clk;
  logic       rst_n;
  logic       start_i [2];
  logic [7:0] exp_i   [2];
  logic [7:0] fn      [2];
  logic       y_i     [2];
  logic       a_o     [2];
  logic       b_o     [2];
  logic       c_o     [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic       pass_o  [2];
  logic [7:0] tt_o    [2];
  logic [7:0] mm_o    [2];

  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_fail;
  bit          prev_done [2];
  bit          act_v     [2];
  int unsigned act_s     [2];
  sb_t         sb0 [$];
  sb_t         sb1 [$];

  // Blocks under scan: y is the function table indexed by {a,b,c}.
  assign y_i[0] = fn[0][{a_o[0], b_o[0], c_o[0]}];
  assign y_i[1] = fn[1][{a_o[1], b_o[1], c_o[1]}];

  truth_table_scanner #(.SETTLE_CYCLES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .expected(exp_i[0]),
    .y(y_i[0]), .a(a_o[0]), .b(b_o[0]), .c(c_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .pass(pass_o[0]), .truth_table(tt_o[0]),
    .mismatch(mm_o[0])
  );

  truth_table_scanner #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .expected(exp_i[1]),
    .y(y_i[1]), .a(a_o[1]), .b(b_o[1]), .c(c_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .pass(pass_o[1]), .truth_table(tt_o[1]),
    .mismatch(mm_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned s_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int unsigned done_rel(input int i);
    return 8 * (s_of(i) + 1) + 1;
  endfunction

  task automatic chk(input int i, input string nm, input int unsigned act,
                     input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL u%0d %s: got %0h expected %0h at cycle %0d", i, nm, act, exp, cyc);
    end
  endtask

  // One monitor step for an instance with a pending scan expectation.
  task automatic mon_step(input int i, input sb_t e, output bit pop);
    int unsigned s;
    int unsigned d;
    int          rel;
    logic [7:0]  mask;
    s    = s_of(i);
    d    = done_rel(i);
    rel  = int'(cyc) - int'(e.start_cyc) + 1;
    pop  = 1'b0;
    mask = '0;
    if (done_o[i] && !prev_done[i]) begin
      chk(i, "done_cycle", 32'(rel), d);
      chk(i, "final_table", 32'(tt_o[i]), 32'(e.tbl));
      chk(i, "pass", 32'(pass_o[i]), 32'(e.pass));
      chk(i, "mismatch", 32'(mm_o[i]), 32'(e.mism));
      chk(i, "busy_at_done", 32'(busy_o[i]), 0);
      chk(i, "abc_at_done", 32'({a_o[i], b_o[i], c_o[i]}), 7);
      pop = 1'b1;
    end else if (rel >= int'(d)) begin
      n_checks++;
      n_fail++;
      $display("FAIL u%0d done_timeout: no done by relative cycle %0d (required %0d)", i, rel, d);
      pop = 1'b1;
    end else begin
      for (int k = 0; k < 8; k++)
        if ((k + 1) * int'(s + 1) + 1 <= rel) mask[k] = 1'b1;
      chk(i, "busy", 32'(busy_o[i]), 1);
      chk(i, "done_low", 32'(done_o[i]), 0);
      chk(i, "pass_low", 32'(pass_o[i]), 0);
      chk(i, "mismatch_low", 32'(mm_o[i]), 0);
      chk(i, "abc", 32'({a_o[i], b_o[i], c_o[i]}), 32'((rel - 1) / int'(s + 1)));
      chk(i, "partial_table", 32'(tt_o[i]), 32'(e.tbl & mask));
    end
  endtask

  // Monitor: checks each instance one step after every rising edge.
  always @(posedge clk) begin
    bit p;
    #1;
    if (rst_n) begin
      if (sb0.size() > 0) begin
        mon_step(0, sb0[0], p);
        if (p) void'(sb0.pop_front());
      end else if (done_o[0] && !prev_done[0]) begin
        chk(0, "unexpected_done", 32'(done_o[0]), 0);
      end
      if (sb1.size() > 0) begin
        mon_step(1, sb1[0], p);
        if (p) void'(sb1.pop_front());
      end else if (done_o[1] && !prev_done[1]) begin
        chk(1, "unexpected_done", 32'(done_o[1]), 0);
      end
    end
    prev_done[0] = done_o[0];
    prev_done[1] = done_o[1];
  end

  // Pulse start for one cycle; queue an expectation if the scanner is idle or done.
  task automatic start_scan(input int i, input logic [7:0] e);
    sb_t ent;
    bit  acc;
    @(negedge clk);
    acc = !act_v[i] || ((cyc + 1 - act_s[i]) >= done_rel(i));
    start_i[i] = 1'b1;
    exp_i[i]   = e;
    if (acc) begin
      ent.tbl       = 8'h00;
      for (int k = 0; k < 8; k++) ent.tbl[k] = fn[i][k];
      ent.mism      = ent.tbl ^ e;
      ent.pass      = (ent.tbl == e);
      ent.start_cyc = cyc + 1;
      if (i == 0) sb0.push_back(ent);
      else        sb1.push_back(ent);
      act_v[i] = 1'b1;
      act_s[i] = cyc + 1;
    end
    @(negedge clk);
    start_i[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (((i == 0) ? sb0.size() : sb1.size()) > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (((i == 0) ? sb0.size() : sb1.size()) > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL u%0d wait_idle: scan still pending after %0d cycles (required completion)", i, n);
      if (i == 0) sb0.delete();
      else        sb1.delete();
    end
  endtask

  // Assert reset between clock edges and check outputs clear without an edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(i, "rst_abc", 32'({a_o[i], b_o[i], c_o[i]}), 0);
      chk(i, "rst_busy", 32'(busy_o[i]), 0);
      chk(i, "rst_done", 32'(done_o[i]), 0);
      chk(i, "rst_pass", 32'(pass_o[i]), 0);
      chk(i, "rst_table", 32'(tt_o[i]), 0);
      chk(i, "rst_mismatch", 32'(mm_o[i]), 0);
      act_v[i]     = 1'b0;
      prev_done[i] = 1'b0;
    end
    sb0.delete();
    sb1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int          i;
    int unsigned s;
    logic [7:0]  e;
    cyc        = 0;
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    start_i[0] = 1'b0;
    start_i[1] = 1'b0;
    exp_i[0]   = 8'h00;
    exp_i[1]   = 8'h00;
    for (int k = 0; k < 8; k++) begin
      fn[0][k] = (k[2] & k[1]) | k[0];
      fn[1][k] = k[2] ^ k[1] ^ k[0];
    end
    act_v[0] = 1'b0;
    act_v[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_reset();
    start_scan(0, 8'hEA);           // matching scan
    wait_idle(0);
    start_scan(0, 8'hEB);           // restart from done, row 0 differs
    wait_idle(0);
    start_scan(0, 8'hEA);
    repeat (8) @(negedge clk);
    start_scan(0, 8'h00);           // ignored while busy
    wait_idle(0);
    start_scan(0, 8'hEA);
    repeat (18) @(negedge clk);
    do_reset();                     // reset mid-scan, then a fresh scan
    start_scan(0, 8'hEA);
    wait_idle(0);
    start_scan(1, 8'h96);           // minimum settle time
    wait_idle(1);

    for (int it = 0; it < 30; it++) begin
      i = int'($urandom_range(0, 1));
      s = s_of(i);
      wait_idle(i);
      fn[i] = 8'($urandom);
      e = ($urandom_range(0, 1) == 1) ? fn[i] : 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_scan(i, e);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 8 * (s + 1) + 2)) @(negedge clk);
        start_scan(i, 8'($urandom));
      end
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 8 * (s + 1) - 2)) @(negedge clk);
        do_reset();
      end
    end
    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
